// File: rtl/avm_burst_if.sv
// rtl/avm_burst_if.sv - Avalon-MM burst bus bundle between master and responder
interface avm_burst_if #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int BURST_W = 8
);
    logic [ADDR_W-1:0]  avs_address;
    logic [BURST_W-1:0] avs_burstcount;
    logic               avs_write;
    logic [DATA_W-1:0]  avs_writedata;
    logic               avs_read;
    logic               avs_waitrequest;
    logic [DATA_W-1:0]  avs_readdata;
    logic               avs_readdatavalid;

    modport master (
        output avs_address, avs_burstcount, avs_write, avs_writedata, avs_read,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_burstcount, avs_write, avs_writedata, avs_read,
        output avs_waitrequest, avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/avm_burst_responder.sv
// rtl/avm_burst_responder.sv - RAM-backed Avalon-MM burst slave with fixed read latency
module avm_burst_responder #(
    parameter int ADDR_W       = 25,
    parameter int DATA_W       = 16,
    parameter int BURST_W      = 8,
    parameter int MEM_AW       = 10,
    parameter int READ_LATENCY = 2,
    parameter int WAIT_PERIOD  = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    avm_burst_if.slave  avs,
    output logic [15:0] wr_burst_cnt,
    output logic [15:0] rd_burst_cnt,
    output logic        err_flag
);
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RD_WAIT, S_READ} state_t;

    state_t             state, state_nxt;
    logic [MEM_AW-1:0]  ptr;
    logic [BURST_W-1:0] left;
    logic [15:0]        stall_cnt;
    logic [15:0]        lat_cnt;
    logic [DATA_W-1:0]  mem [2**MEM_AW];

    logic [MEM_AW-1:0]  cmd_addr;
    logic [BURST_W-1:0] req_len;
    logic               stall_hit;
    logic               wr_acc;
    logic               unused_addr_hi;

    assign cmd_addr       = avs.avs_address[MEM_AW-1:0];
    assign unused_addr_hi = ^avs.avs_address[ADDR_W-1:MEM_AW];
    // A zero burstcount is serviced as a single beat (and flagged below).
    assign req_len   = (avs.avs_burstcount == '0) ? BURST_W'(1) : avs.avs_burstcount;
    assign stall_hit = (WAIT_PERIOD > 0) && (stall_cnt == 16'(WAIT_PERIOD - 1));
    assign wr_acc    = avs.avs_write && !avs.avs_waitrequest;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (avs.avs_write)
                    state_nxt = (req_len == BURST_W'(1)) ? S_IDLE : S_WRITE;
                else if (avs.avs_read)
                    state_nxt = (READ_LATENCY <= 1) ? S_READ : S_RD_WAIT;
            end
            S_WRITE:   if (wr_acc && left == BURST_W'(1)) state_nxt = S_IDLE;
            S_RD_WAIT: if (lat_cnt == 16'd0) state_nxt = S_READ;
            S_READ:    if (left == '0) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        avs.avs_waitrequest = 1'b1;
        case (state)
            S_IDLE:  avs.avs_waitrequest = 1'b0;
            S_WRITE: avs.avs_waitrequest = stall_hit;
            default: avs.avs_waitrequest = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && avs.avs_write)
            mem[cmd_addr] <= avs.avs_writedata;
        else if (state == S_WRITE && wr_acc)
            mem[ptr] <= avs.avs_writedata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr                   <= '0;
            left                  <= '0;
            stall_cnt             <= '0;
            lat_cnt               <= '0;
            avs.avs_readdata      <= '0;
            avs.avs_readdatavalid <= 1'b0;
            wr_burst_cnt          <= '0;
            rd_burst_cnt          <= '0;
            err_flag              <= 1'b0;
        end else begin
            avs.avs_readdatavalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    stall_cnt <= '0;
                    if (avs.avs_write) begin
                        ptr  <= cmd_addr + 1'b1;
                        left <= req_len - 1'b1;
                        if (avs.avs_burstcount == '0 || avs.avs_read) err_flag <= 1'b1;
                        if (req_len == BURST_W'(1)) wr_burst_cnt <= wr_burst_cnt + 16'd1;
                    end else if (avs.avs_read) begin
                        ptr     <= cmd_addr;
                        left    <= req_len;
                        lat_cnt <= 16'(READ_LATENCY >= 2 ? READ_LATENCY - 2 : 0);
                        if (avs.avs_burstcount == '0) err_flag <= 1'b1;
                    end
                end
                S_WRITE: begin
                    stall_cnt <= stall_hit ? 16'd0 : stall_cnt + 16'd1;
                    if (avs.avs_read) err_flag <= 1'b1;
                    if (wr_acc) begin
                        ptr  <= ptr + 1'b1;
                        left <= left - 1'b1;
                        if (left == BURST_W'(1)) wr_burst_cnt <= wr_burst_cnt + 16'd1;
                    end
                end
                S_RD_WAIT: lat_cnt <= lat_cnt - 16'd1;
                S_READ: begin
                    // One extra READ cycle after the last beat retires the burst.
                    if (left != '0) begin
                        avs.avs_readdata      <= mem[ptr];
                        avs.avs_readdatavalid <= 1'b1;
                        ptr                   <= ptr + 1'b1;
                        left                  <= left - 1'b1;
                    end else begin
                        rd_burst_cnt <= rd_burst_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/avm_burst_responder.md
Name: avm_burst_responder

Overview:
- Avalon-MM burst slave: the responder end of the interface driven by avm_write_control and avm_read_control.
- Backs accepted beats with an internal synchronous RAM and returns read bursts with fixed latency.
- Used as a simulation and on-chip stand-in for the SDRAM path, so the masters can be exercised without the SDRAM controller.
- Supports optional periodic waitrequest stalls to stress master handshakes.

Parameters:
- ADDR_W, 25, word address width on the interface.
- DATA_W, 16, data width.
- BURST_W, 8, burstcount width.
- MEM_AW, 10, internal RAM address bits (2^MEM_AW words). Only the low MEM_AW address bits are used; upper bits are ignored.
- READ_LATENCY, 2, cycles from read command acceptance to the first readdatavalid. Legal range is >=1.
- WAIT_PERIOD, 0, stall spacing. 0 means no stalls. N>0 means waitrequest is high 1 cycle in every N while in WRITE.

Ports:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  ADDR_W  word address; sampled on the first beat of a burst only.
- avs_burstcount  in  BURST_W  beats in the burst; sampled with the address.
- avs_write  in  1  write request / write beat valid.
- avs_writedata  in  DATA_W  write beat data.
- avs_read  in  1  read command.
- avs_waitrequest  out  1  high means the current command or beat is not accepted.
- avs_readdata  out  DATA_W  read beat data.
- avs_readdatavalid  out  1  avs_readdata is valid this cycle.
- wr_burst_cnt  out  16  completed write bursts, wraps at 2^16.
- rd_burst_cnt  out  16  completed read bursts, wraps at 2^16.
- err_flag  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE.
  - Outputs: waitrequest=0, readdatavalid=0, readdata=0, both counters=0, err_flag=0.
  - Stall counter=0.
  - RAM contents are not reset.
- State machine: IDLE, WRITE, RD_WAIT, READ.
- avs_waitrequest is combinational from state:
  - 0 in IDLE.
  - Stall pulse in WRITE.
  - 1 in RD_WAIT and READ.
- Beat acceptance: a beat or command is accepted when (avs_write or avs_read) is high and avs_waitrequest is low on the same rising edge.
- IDLE, write accepted:
  - Latch addr=avs_address[MEM_AW-1:0] and len=avs_burstcount.
  - Write beat 0 to RAM[addr].
  - If len<=1, go to IDLE and increment wr_burst_cnt. Otherwise go to WRITE with remaining=len-1.
- WRITE:
  - Each accepted beat writes RAM[addr+i], with i counting accepted beats.
  - Address arithmetic is modulo 2^MEM_AW, so bursts wrap from 2^MEM_AW-1 to 0.
  - avs_address and avs_burstcount are ignored here.
  - Last beat accepted: go to IDLE and increment wr_burst_cnt.
  - Cycles with write low or waitrequest high do not advance the burst.
- IDLE, read accepted (write low):
  - Latch addr and len. Go to RD_WAIT.
  - First readdatavalid is exactly READ_LATENCY cycles after the accept edge.
- RD_WAIT / READ:
  - Emit len beats on consecutive cycles, readdata=RAM[addr+k], k=0..len-1, with wrap.
  - readdatavalid is high for exactly len cycles. readdata is held stable (last value) when not valid.
  - The cycle after the last beat: state=IDLE, rd_burst_cnt++. New commands are accepted from that cycle.
- burstcount=0: treated as a 1-beat burst; sets err_flag.
- Write and read both high in IDLE: write wins; sets err_flag; the read is not accepted.
- Read asserted in WRITE: ignored; sets err_flag.
- Stall generation (WAIT_PERIOD=N>0):
  - A counter runs only in WRITE and resets to 0 on entry.
  - waitrequest=1 when counter==N-1; the counter then returns to 0.
  - No stalls in IDLE, so the first beat of a write is always accepted immediately.
- err_flag is cleared only by reset.
- Reset mid-burst: immediate return to IDLE. readdatavalid drops in the same cycle reset asserts. The partial burst is not counted.
- Readdata is a registered RAM output, so READ_LATENCY>=1 is mandatory. No back-to-back read pipelining: one outstanding burst at a time.

Test Plan:
- Write burst, addr=0x10, burstcount=4, data 0xA000..0xA003 (WAIT_PERIOD=0), then read addr=0x10 burstcount=4 accepted at edge T -> readdatavalid high on T+2..T+5 with 0xA000..0xA003; wr_burst_cnt=1, rd_burst_cnt=1, err_flag=0.
- Wrap: write addr=0x3FE burstcount=4 data 1,2,3,4 -> reading addr 0x000 count 2 returns 3,4; reading 0x3FE count 2 returns 1,2.
- Write with burstcount=0, data 0x5555 at addr 0x20 -> one beat stored, state IDLE next cycle, err_flag=1, wr_burst_cnt=1.
- Write and read both high in IDLE at addr 0x30 -> write accepted, no readdatavalid follows, err_flag=1.
- WAIT_PERIOD=3, 8-beat write with master holding write high -> waitrequest high on cycles 2, 5, 8 of WRITE. All 8 values land at consecutive addresses; read-back matches.
- Start a 16-beat read, assert reset_n low after the 3rd readdatavalid -> readdatavalid=0 at once, waitrequest=0 and rd_burst_cnt=0 after release. A new read of 2 beats completes normally.
